// File: rtl/fetch_pkg.sv
// Shared widths and FSM encodings for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned PC_W    = 72;
    localparam int unsigned JUMP_W  = 68;
    localparam int unsigned BR_W    = 55;
    localparam int unsigned INSTR_W = 60;

    localparam int unsigned ST_W = 2;
    typedef logic [ST_W-1:0] fetch_state_t;

    localparam fetch_state_t IDLE = 2'd0;
    localparam fetch_state_t REQ  = 2'd1;
    localparam fetch_state_t WAIT = 2'd2;
    localparam fetch_state_t OUT  = 2'd3;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: redirect mux (branch over jump, zero-extended targets) and wrapping increment.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W   = fetch_pkg::PC_W,
    parameter int unsigned BR_W   = fetch_pkg::BR_W,
    parameter int unsigned JUMP_W = fetch_pkg::JUMP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_i,
    input  logic [BR_W-1:0]   branch_addr_i,
    input  logic              jump_i,
    input  logic [JUMP_W-1:0] jump_addr_i,
    input  logic              inc_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [PC_W-1:0]   pc_next_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // A redirect always beats the sequential increment.
    always_comb begin
        pc_d = pc_q;
        if (branch_i) begin
            pc_d = PC_W'(branch_addr_i);
        end else if (jump_i) begin
            pc_d = PC_W'(jump_addr_i);
        end else if (inc_i) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o      = pc_q;
    assign pc_next_o = pc_d;

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: one outstanding imem request, stale-response drop on redirect,
// registered hand-off to decode.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W    = fetch_pkg::PC_W,
    parameter int unsigned JUMP_W  = fetch_pkg::JUMP_W,
    parameter int unsigned BR_W    = fetch_pkg::BR_W,
    parameter int unsigned INSTR_W = fetch_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               branch_taken,
    input  logic [BR_W-1:0]    branch_addr,
    input  logic               jump,
    input  logic [JUMP_W-1:0]  jump_addr,
    output logic [PC_W-1:0]    pc,
    output logic               busy
);

    fetch_state_t       state_q, state_d;
    fetch_state_t       resume_st;
    logic               drop_q, drop_d;
    logic               redirect;
    logic               pc_inc;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_next;
    logic               req_valid_q;
    logic [PC_W-1:0]    req_addr_q, req_addr_d;
    logic               instr_valid_q;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
    logic               busy_q;

    assign redirect  = branch_taken | jump;
    assign resume_st = run ? REQ : IDLE;

    fetch_pc_reg #(
        .PC_W   (PC_W),
        .BR_W   (BR_W),
        .JUMP_W (JUMP_W)
    ) u_pc (
        .clk           (clk),
        .rst           (rst),
        .branch_i      (branch_taken),
        .branch_addr_i (branch_addr),
        .jump_i        (jump),
        .jump_addr_i   (jump_addr),
        .inc_i         (pc_inc),
        .pc_o          (pc_q),
        .pc_next_o     (pc_next)
    );

    // Next state, drop flag and capture data.
    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        pc_inc     = 1'b0;
        req_addr_d = req_addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        case (state_q)
            IDLE: begin
                if (run) state_d = REQ;
            end
            REQ: begin
                if (redirect) drop_d = 1'b1;
                if (imem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    // A redirect landing with the response makes it stale without arming drop.
                    if (drop_q || redirect) begin
                        drop_d  = 1'b0;
                        state_d = resume_st;
                    end else begin
                        instr_d    = imem_rsp_data;
                        instr_pc_d = pc_q;
                        state_d    = OUT;
                    end
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            OUT: begin
                if (redirect) begin
                    state_d = resume_st;
                end else if (instr_ready) begin
                    pc_inc  = 1'b1;
                    state_d = resume_st;
                end
            end
            default: state_d = IDLE;
        endcase
        // Request address is latched on REQ entry so it holds even if pc is redirected.
        if ((state_d == REQ) && (state_q != REQ)) req_addr_d = pc_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            drop_q        <= 1'b0;
            req_valid_q   <= 1'b0;
            req_addr_q    <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            drop_q        <= drop_d;
            req_valid_q   <= (state_d == REQ);
            req_addr_q    <= req_addr_d;
            instr_valid_q <= (state_d == OUT);
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            busy_q        <= (state_d != IDLE);
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_addr_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign pc             = pc_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a latency-programmable instruction memory model.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [71:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [59:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready;
    logic [59:0] instr;
    logic [71:0] instr_pc;
    logic        branch_taken;
    logic [54:0] branch_addr;
    logic        jump;
    logic [67:0] jump_addr;
    logic [71:0] pc;
    logic        busy;

    logic        w_br, w_j, w_inc;
    logic [7:0]  w_br_addr;
    logic [5:0]  w_j_addr;
    logic [7:0]  w_pc, w_pc_next;

    int          errors = 0;
    int          checks = 0;
    int          mem_lat = 1;
    int          wait_cnt = 0;
    logic [71:0] pend_addr = '0;
    int          n;

    always #5 clk = ~clk;

    fetch_controller u_dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .branch_taken   (branch_taken),
        .branch_addr    (branch_addr),
        .jump           (jump),
        .jump_addr      (jump_addr),
        .pc             (pc),
        .busy           (busy)
    );

    // Narrow pc register instance so the all-ones wrap is reachable through a redirect.
    fetch_pc_reg #(.PC_W(8), .BR_W(8), .JUMP_W(6)) u_pcw (
        .clk           (clk),
        .rst           (rst),
        .branch_i      (w_br),
        .branch_addr_i (w_br_addr),
        .jump_i        (w_j),
        .jump_addr_i   (w_j_addr),
        .inc_i         (w_inc),
        .pc_o          (w_pc),
        .pc_next_o     (w_pc_next)
    );

    function automatic logic [59:0] mem_word(input logic [71:0] a);
        return {4'hA, a[27:0], ~a[27:0]};
    endfunction

    // Memory: answers mem_lat cycles after the accepting cycle.
    always @(negedge clk) begin
        logic        rv;
        logic [59:0] rd;
        rv = 1'b0;
        rd = '0;
        if (wait_cnt != 0) begin
            wait_cnt = wait_cnt - 1;
            if (wait_cnt == 0) begin
                rv = 1'b1;
                rd = mem_word(pend_addr);
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            wait_cnt  = mem_lat;
            pend_addr = imem_req_addr;
        end
        imem_rsp_valid = rv;
        imem_rsp_data  = rd;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance at least one cycle, then until instr_valid (bounded), and check the delivered word.
    task automatic wait_instr(input logic [71:0] exp_pc, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!instr_valid && cyc < 20);
        chk("instr_valid_seen", 72'(instr_valid), 72'd1);
        chk("instr_pc", instr_pc, exp_pc);
        chk("instr", 72'(instr), 72'(mem_word(exp_pc)));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, 72'(u_dut.state_q), 72'd0);
        chk({tag, "_drop"}, 72'(u_dut.drop_q), 72'd0);
        chk({tag, "_req_valid"}, 72'(imem_req_valid), 72'd0);
        chk({tag, "_req_addr"}, imem_req_addr, 72'd0);
        chk({tag, "_instr_valid"}, 72'(instr_valid), 72'd0);
        chk({tag, "_instr"}, 72'(instr), 72'd0);
        chk({tag, "_instr_pc"}, instr_pc, 72'd0);
        chk({tag, "_pc"}, pc, 72'd0);
        chk({tag, "_busy"}, 72'(busy), 72'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; run = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
        branch_taken = 1'b0; branch_addr = '0; jump = 1'b0; jump_addr = '0;
        w_br = 1'b0; w_j = 1'b0; w_inc = 1'b0; w_br_addr = '0; w_j_addr = '0;
        repeat (3) step();
        chk_all_zero("reset");

        // Straight-line fetch: A,B,C at 0,1,2, 3-cycle latency and throughput.
        rst = 1'b0; run = 1'b1;
        step();
        chk("first_req_valid", 72'(imem_req_valid), 72'd1);
        chk("first_req_addr", imem_req_addr, 72'd0);
        chk("first_busy", 72'(busy), 72'd1);
        chk("first_instr_valid_lo", 72'(instr_valid), 72'd0);
        step();
        chk("wait_instr_valid_lo", 72'(instr_valid), 72'd0);
        step();
        chk("lat3_instr_valid", 72'(instr_valid), 72'd1);
        chk("lat3_instr_pc", instr_pc, 72'd0);
        chk("lat3_instr", 72'(instr), 72'(mem_word(72'd0)));
        wait_instr(72'd1, n);
        chk("throughput_b", 72'(n), 72'd3);
        wait_instr(72'd2, n);
        chk("throughput_c", 72'(n), 72'd3);
        wait_instr(72'd3, n);
        wait_instr(72'd4, n);

        // Branch during WAIT coincident with the response for pc=5.
        step();
        chk("pc5_req_addr", imem_req_addr, 72'd5);
        step();
        chk("pc5_state_wait", 72'(u_dut.state_q), 72'd2);
        branch_taken = 1'b1; branch_addr = 55'h100;
        step();
        branch_taken = 1'b0;
        chk("br_pc", pc, 72'h100);
        chk("br_req_addr", imem_req_addr, 72'h100);
        chk("br_req_valid", 72'(imem_req_valid), 72'd1);
        chk("br_drop_clear", 72'(u_dut.drop_q), 72'd0);
        chk("br_instr_valid_lo", 72'(instr_valid), 72'd0);
        wait_instr(72'h100, n);

        // Jump during WAIT before the response: drop set, then stale response drained.
        mem_lat = 3;
        step();
        chk("slow_req_addr", imem_req_addr, 72'h101);
        step();
        jump = 1'b1; jump_addr = 68'h300;
        step();
        jump = 1'b0;
        chk("jw_drop_set", 72'(u_dut.drop_q), 72'd1);
        chk("jw_pc", pc, 72'h300);
        chk("jw_state_wait", 72'(u_dut.state_q), 72'd2);
        step();
        step();
        chk("jw_drop_clr", 72'(u_dut.drop_q), 72'd0);
        chk("jw_req_valid", 72'(imem_req_valid), 72'd1);
        chk("jw_req_addr", imem_req_addr, 72'h300);
        chk("jw_instr_valid_lo", 72'(instr_valid), 72'd0);
        mem_lat = 1;
        wait_instr(72'h300, n);

        // Branch and jump together in OUT with instr_ready high: branch wins, no increment.
        branch_taken = 1'b1; branch_addr = 55'h40; jump = 1'b1; jump_addr = 68'h80;
        step();
        branch_taken = 1'b0; jump = 1'b0;
        chk("prio_pc", pc, 72'h40);
        chk("prio_req_addr", imem_req_addr, 72'h40);
        chk("prio_instr_valid_lo", 72'(instr_valid), 72'd0);
        wait_instr(72'h40, n);

        // Memory not ready for 4 cycles, jump mid-hold.
        imem_req_ready = 1'b0;
        step();
        chk("hold0_valid", 72'(imem_req_valid), 72'd1);
        chk("hold0_addr", imem_req_addr, 72'h41);
        step();
        chk("hold1_addr", imem_req_addr, 72'h41);
        jump = 1'b1; jump_addr = 68'h20;
        step();
        jump = 1'b0;
        chk("hold2_valid", 72'(imem_req_valid), 72'd1);
        chk("hold2_addr", imem_req_addr, 72'h41);
        chk("hold2_pc", pc, 72'h20);
        chk("hold2_drop", 72'(u_dut.drop_q), 72'd1);
        step();
        chk("hold3_addr", imem_req_addr, 72'h41);
        chk("hold3_valid", 72'(imem_req_valid), 72'd1);
        imem_req_ready = 1'b1;
        step();
        chk("hold_wait_state", 72'(u_dut.state_q), 72'd2);
        chk("hold_wait_drop", 72'(u_dut.drop_q), 72'd1);
        step();
        chk("hold_reissue_addr", imem_req_addr, 72'h20);
        chk("hold_reissue_valid", 72'(imem_req_valid), 72'd1);
        chk("hold_drop_clr", 72'(u_dut.drop_q), 72'd0);
        chk("hold_instr_valid_lo", 72'(instr_valid), 72'd0);
        wait_instr(72'h20, n);

        // Decode stall for 5 cycles, then reset mid-hold.
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", 72'(instr_valid), 72'd1);
            chk("stall_instr", 72'(instr), 72'(mem_word(72'h20)));
            chk("stall_instr_pc", instr_pc, 72'h20);
            chk("stall_pc", pc, 72'h20);
        end
        rst = 1'b1;
        step();
        chk_all_zero("midrst");

        // run dropped mid-transaction: fetch completes, then IDLE.
        rst = 1'b0; instr_ready = 1'b1;
        step();
        chk("r0_req_addr", imem_req_addr, 72'd0);
        run = 1'b0;
        step();
        step();
        chk("r0_instr_valid", 72'(instr_valid), 72'd1);
        chk("r0_instr", 72'(instr), 72'(mem_word(72'd0)));
        step();
        chk("r0_idle_state", 72'(u_dut.state_q), 72'd0);
        chk("r0_busy", 72'(busy), 72'd0);
        chk("r0_req_valid", 72'(imem_req_valid), 72'd0);
        chk("r0_pc", pc, 72'd1);
        step();
        chk("r0_still_idle", 72'(busy), 72'd0);

        // Wrap and zero-extension on the narrow pc register.
        w_br = 1'b1; w_br_addr = 8'hFF;
        step();
        w_br = 1'b0;
        chk("wrap_max", 72'(w_pc), 72'hFF);
        w_inc = 1'b1;
        step();
        w_inc = 1'b0;
        chk("wrap_zero", 72'(w_pc), 72'h00);
        w_j = 1'b1; w_j_addr = 6'h3F;
        step();
        chk("jump_zext", 72'(w_pc), 72'h3F);
        w_br = 1'b1; w_br_addr = 8'h12;
        step();
        w_br = 1'b0; w_j = 1'b0;
        chk("narrow_prio", 72'(w_pc), 72'h12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
